// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared types and constants for the memory access unit:
//               FSM state encoding, RV32I load/store width codes, error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // RV32I funct3 width codes (loads and stores share 000/001/010)
  localparam logic [2:0] c_F3_BYTE   = 3'b000;  // LB / SB
  localparam logic [2:0] c_F3_HALF   = 3'b001;  // LH / SH
  localparam logic [2:0] c_F3_WORD   = 3'b010;  // LW / SW / ifetch
  localparam logic [2:0] c_F3_BYTE_U = 3'b100;  // LBU
  localparam logic [2:0] c_F3_HALF_U = 3'b101;  // LHU

  // Error codes reported alongside err
  localparam logic [1:0] c_ERR_NONE     = 2'b00;
  localparam logic [1:0] c_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] c_ERR_FUNCT3   = 2'b11;

  localparam logic [3:0] c_BE_ALL = 4'b1111;

  // Request-time error; an illegal width code outranks misalignment
  function automatic logic [1:0] err_select(input logic illegal, input logic misaligned);
    if (illegal) begin
      return c_ERR_FUNCT3;
    end else if (misaligned) begin
      return c_ERR_MISALIGN;
    end else begin
      return c_ERR_NONE;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_align
// Description : Combinational RV32I lane logic: byte enables and replicated
//               store lanes, load lane select with sign/zero extension, and
//               width-code legality / alignment flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic            store_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wlanes_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o,
  output logic            misaligned_o
);

  // Memory word shifted so the addressed byte/half sits in the low lanes
  logic [XLEN-1:0] w_shifted;
  assign w_shifted = rdata_i >> {addr_lo_i, 3'b000};

  // Decode the width code into lanes, extension and legality
  always_comb begin
    be_o         = c_BE_ALL;
    wlanes_o     = wdata_i;
    rdata_o      = rdata_i;
    illegal_o    = 1'b0;
    misaligned_o = 1'b0;
    unique case (funct3_i)
      c_F3_BYTE: begin
        be_o     = 4'b0001 << addr_lo_i;
        wlanes_o = {(XLEN/8){wdata_i[7:0]}};
        rdata_o  = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      end
      c_F3_HALF: begin
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << addr_lo_i;
        wlanes_o     = {(XLEN/16){wdata_i[15:0]}};
        rdata_o      = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      end
      c_F3_WORD: begin
        misaligned_o = |addr_lo_i;
      end
      c_F3_BYTE_U: begin
        // Unsigned widths exist only for loads
        illegal_o = store_i;
        be_o      = 4'b0001 << addr_lo_i;
        rdata_o   = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      end
      c_F3_HALF_U: begin
        illegal_o    = store_i;
        misaligned_o = addr_lo_i[0];
        be_o         = 4'b0011 << addr_lo_i;
        rdata_o      = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Single-access memory sequencer between the multi-cycle control
//               FSM and shared instruction/data memory. Drives a req/ack
//               handshake with optional timeout, formats load data and flags
//               misaligned, illegal-width and timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic            req_ifetch,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  // Counter is wide enough that reaching TIMEOUT never coincides with saturation
  localparam int                 c_CNT_W   = $clog2(TIMEOUT + 2);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;

  logic              w_idle;
  logic              w_store;
  logic [2:0]        w_funct3;
  logic [2:0]        w_al_funct3;
  logic              w_al_store;
  logic [1:0]        w_al_addr_lo;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wlanes;
  logic [XLEN-1:0]   w_rdata_fmt;
  logic              w_illegal;
  logic              w_misaligned;
  logic [c_CNT_W-1:0] w_cnt_inc;

  // Instruction fetch forces a word load regardless of funct3/req_write
  assign w_store  = req_write & ~req_ifetch;
  assign w_funct3 = req_ifetch ? c_F3_WORD : funct3;

  // One lane unit serves both phases: request decode in IDLE, load formatting
  // from the latched width/offset while the access is outstanding
  assign w_idle       = (state_q == ST_IDLE);
  assign w_al_funct3  = w_idle ? w_funct3  : funct3_q;
  assign w_al_store   = w_idle ? w_store   : mem_we_q;
  assign w_al_addr_lo = w_idle ? addr[1:0] : addr_lo_q;

  mem_access_unit_align #(
    .XLEN (XLEN)
  ) u_align (
    .funct3_i     (w_al_funct3),
    .store_i      (w_al_store),
    .addr_lo_i    (w_al_addr_lo),
    .wdata_i      (wdata),
    .rdata_i      (mem_rdata),
    .be_o         (w_be),
    .wlanes_o     (w_wlanes),
    .rdata_o      (w_rdata_fmt),
    .illegal_o    (w_illegal),
    .misaligned_o (w_misaligned)
  );

  assign w_cnt_inc = cnt_q + 1'b1;

  // Next-state, request capture, ack/timeout handling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_code_d  = c_ERR_NONE;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_illegal || w_misaligned) begin
            // Rejected before any memory traffic
            state_d    = ST_DONE;
            err_code_d = err_select(w_illegal, w_misaligned);
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_we_d    = w_store;
            mem_be_d    = w_store ? w_be : c_BE_ALL;
            mem_wdata_d = w_store ? w_wlanes : '0;
            funct3_d    = w_funct3;
            addr_lo_d   = addr[1:0];
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!mem_we_q) begin
            rdata_d = w_rdata_fmt;
          end
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : w_cnt_inc;
          if ((TIMEOUT != 0) && (w_cnt_inc == c_TIMEOUT)) begin
            state_d    = ST_DONE;
            err_code_d = c_ERR_TIMEOUT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_code_q  <= c_ERR_NONE;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_code_q  <= err_code_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  // err_code_q is only ever non-zero while in DONE
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = |err_code_q;
  assign err_code  = err_code_q;
  assign rdata     = rdata_q;
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_we    = mem_we_q & (state_q == ST_ACCESS);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed scoreboard bench for mem_access_unit. Stimulus pushes
//               expected memory-side and completion-side responses; a single
//               monitor pops and compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_write, req_ifetch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] addr, wdata;
  logic            busy, done, err;
  logic [1:0]      err_code;
  logic [XLEN-1:0] rdata;
  logic            mem_req, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  typedef struct { logic [1:0] code; logic [31:0] rd; int cyc; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; } mem_t;

  done_t dq[$];
  mem_t  mq[$];

  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          wait_fail_req = 0;
  int          wait_fail_seen = 0;
  bit          chk_zero = 0;
  bit          chk_idle = 0;
  bit          chk_end = 0;
  logic [31:0] chk_rd = '0;
  bit          prev_req = 0;

  mem_access_unit #(
    .XLEN    (XLEN),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_ifetch (req_ifetch),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Cycle counter for completion-latency checks
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: all comparisons happen here, on the falling edge
  always @(negedge clk) begin
    if (chk_zero) begin
      n_vec++;
      if ({busy, done, err, mem_req, mem_we} !== 5'b0 || err_code !== 2'b00 || rdata !== 32'h0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_state: busy=%0b done=%0b err=%0b code=%b rdata=%h req=%0b we=%0b addr=%h wdata=%h be=%b, required all zero",
                 busy, done, err, err_code, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
      end
    end
    if (chk_idle) begin
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || rdata !== chk_rd) begin
        n_fail++;
        $display("FAIL ack_in_idle: busy=%0b done=%0b req=%0b rdata=%h, required 0 0 0 %h",
                 busy, done, mem_req, rdata, chk_rd);
      end
    end
    if (rst_n && mem_req && !prev_req) begin
      n_vec++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL mem_req_unexpected: mem_req=1 addr=%h, required no memory request", mem_addr);
      end else begin
        mem_t m;
        m = mq.pop_front();
        if (mem_we !== m.we || mem_addr !== m.addr || mem_be !== m.be || (m.we && mem_wdata !== m.wd)) begin
          n_fail++;
          $display("FAIL mem_side: we=%0b addr=%h be=%b wdata=%h, required we=%0b addr=%h be=%b wdata=%h",
                   mem_we, mem_addr, mem_be, mem_wdata, m.we, m.addr, m.be, m.wd);
        end
      end
    end
    prev_req = rst_n && mem_req;
    if (rst_n && done) begin
      n_vec++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, required no completion", cyc);
      end else begin
        done_t d;
        d = dq.pop_front();
        if (err !== (d.code != 2'b00) || err_code !== d.code || rdata !== d.rd || cyc != d.cyc) begin
          n_fail++;
          $display("FAIL completion: err=%0b code=%b rdata=%h cycle=%0d, required err=%0b code=%b rdata=%h cycle=%0d",
                   err, err_code, rdata, cyc, (d.code != 2'b00), d.code, d.rd, d.cyc);
        end
      end
    end
    if (wait_fail_req != wait_fail_seen) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_bound: busy still %0b after cycle budget, required 0", busy);
      wait_fail_seen = wait_fail_req;
    end
    if (chk_end) begin
      n_vec++;
      if (dq.size() != 0 || mq.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d completions and %0d requests never seen, required 0 and 0",
                 dq.size(), mq.size());
      end
    end
  end

  // One access: lat = cycles of mem_req before ack; lat < 0 means never ack
  task automatic do_access(input bit wr, input bit ifch, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                           input int lat, input logic [1:0] ecode, input logic [31:0] erd,
                           input bit ewe, input logic [31:0] eaddr, input logic [3:0] ebe,
                           input logic [31:0] ewd);
    done_t d;
    mem_t  m;
    int    issue;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_ifetch = ifch; funct3 = f3; addr = a; wdata = wd;
    issue = cyc;
    d.code = ecode;
    d.rd   = erd;
    if (ecode == 2'b10)      d.cyc = issue + 1 + TO;
    else if (ecode != 2'b00) d.cyc = issue + 1;
    else                     d.cyc = issue + 2 + lat;
    dq.push_back(d);
    if (ecode == 2'b00 || ecode == 2'b10) begin
      m.we = ewe; m.addr = eaddr; m.be = ebe; m.wd = ewd;
      mq.push_back(m);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ecode == 2'b00) begin
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1; mem_rdata = mrd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    begin : wait_idle
      int k;
      for (k = 0; k < 40 && busy; k++) begin
        @(posedge clk); #1;
      end
      if (busy) wait_fail_req++;
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_ifetch = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    chk_zero = 1'b1;
    @(negedge clk); #1;
    chk_zero = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    //        wr ifch f3      addr          wdata         mem_rdata     lat code   exp rdata     we   mem_addr      be       wdata
    do_access(0, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3, 2'b00, 32'hDEAD_BEEF, 0, 32'h0000_0100, 4'b1111, 32'h0);
    do_access(0, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1, 2'b00, 32'hFFFF_FF80, 0, 32'h0000_0100, 4'b1111, 32'h0);
    do_access(0, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 2, 2'b00, 32'h0000_0080, 0, 32'h0000_0100, 4'b1111, 32'h0);
    do_access(0, 0, 3'b001, 32'h0000_0102, 32'h0,        32'h8011_2233, 0, 2'b00, 32'hFFFF_8011, 0, 32'h0000_0100, 4'b1111, 32'h0);
    do_access(0, 0, 3'b101, 32'h0000_0100, 32'h0,        32'h8011_2233, 1, 2'b00, 32'h0000_2233, 0, 32'h0000_0100, 4'b1111, 32'h0);
    // ifetch ignores an illegal funct3 and the write flag
    do_access(1, 1, 3'b011, 32'h0000_0040, 32'h0,        32'h1234_5678, 0, 2'b00, 32'h1234_5678, 0, 32'h0000_0040, 4'b1111, 32'h0);

    // mem_ack while idle must not start anything or touch rdata
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk_rd = 32'h1234_5678; chk_idle = 1'b1;
    @(negedge clk); #1;
    chk_idle = 1'b0;

    // Stores leave rdata at the last loaded value
    do_access(1, 0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,        2, 2'b00, 32'h1234_5678, 1, 32'h0000_0200, 4'b0010, 32'hABAB_ABAB);
    do_access(1, 0, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0, 2'b00, 32'h1234_5678, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
    do_access(1, 0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        1, 2'b00, 32'h1234_5678, 1, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);

    // Request-time errors: no memory traffic, done one cycle after request
    do_access(0, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 2'b01, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);
    do_access(0, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 2'b11, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);
    do_access(1, 0, 3'b100, 32'h0000_0200, 32'h0, 32'h0, 0, 2'b11, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);
    do_access(0, 0, 3'b110, 32'h0000_0101, 32'h0, 32'h0, 0, 2'b11, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);
    do_access(0, 0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 2'b01, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);
    do_access(1, 0, 3'b010, 32'h0000_0206, 32'h0, 32'h0, 0, 2'b01, 32'h1234_5678, 0, 32'h0, 4'h0, 32'h0);

    // Timeout: memory never answers
    do_access(0, 0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1, 2'b10, 32'h1234_5678, 0, 32'h0000_0300, 4'b1111, 32'h0);

    // Asynchronous reset in the middle of an outstanding access
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_ifetch = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
    begin
      mem_t m;
      m.we = 1'b0; m.addr = 32'h0000_0400; m.be = 4'b1111; m.wd = 32'h0;
      mq.push_back(m);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0; chk_zero = 1'b1;
    @(negedge clk); #1;
    chk_zero = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal load after reset release
    do_access(0, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h0000_00FF, 1, 2'b00, 32'h0000_00FF, 0, 32'h0000_0010, 4'b1111, 32'h0);

    repeat (3) @(posedge clk);
    #1 chk_end = 1'b1;
    @(negedge clk); #1;
    chk_end = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global guard against a stalled run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
